// File: rtl/pmp_pkg.sv
// Shared encodings for the sequential PMP checker: A-field modes, cfg layout, privilege levels, FSM states.
// Optional TOR decoding is enabled by defining PMP_TOR_MODE_EN.
package pmp_pkg;

  typedef enum logic [1:0] {
    PMP_A_OFF   = 2'd0,
    PMP_A_TOR   = 2'd1,
    PMP_A_NA4   = 2'd2,
    PMP_A_NAPOT = 2'd3
  } pmp_a_e;

  localparam int unsigned CFG_R_BIT = 0;
  localparam int unsigned CFG_W_BIT = 1;
  localparam int unsigned CFG_X_BIT = 2;
  localparam int unsigned CFG_A_LSB = 3;
  localparam int unsigned CFG_L_BIT = 7;
  localparam int unsigned CFG_W     = 8;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // pmpcfg byte layout {L, 2'b0, A, X, W, R}
  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } pmp_state_e;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Single-entry PMP region matcher: decodes one entry's region and reports overlap and full containment.
// TOR decoding (and its previous-address input) exists only when PMP_TOR_MODE_EN is defined.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pmpaddr_i,
`ifdef PMP_TOR_MODE_EN
  input  logic [ADDR_W-1:0] prev_pmpaddr_i,
`endif
  input  pmp_a_e            a_i,
  input  logic [ADDR_W+2:0] lo_i,
  input  logic [ADDR_W+2:0] hi_i,
  output logic              hit_o,
  output logic              full_o
);

  localparam int unsigned BW = ADDR_W + 3;

  logic [ADDR_W-1:0] napot_mask;
  logic [BW-1:0]     base;
  logic [BW-1:0]     top;
  logic              valid;

  // Region is [base, top); top may reach 2^(ADDR_W+2) so one spare bit is carried
  always_comb begin
    napot_mask = pmpaddr_i ^ (pmpaddr_i + ADDR_W'(1));
    base       = '0;
    top        = '0;
    valid      = 1'b0;
    unique case (a_i)
      PMP_A_NA4: begin
        base  = {1'b0, pmpaddr_i, 2'b00};
        top   = base + BW'(4);
        valid = 1'b1;
      end
      PMP_A_NAPOT: begin
        base  = {1'b0, pmpaddr_i & ~napot_mask, 2'b00};
        top   = base + {1'b0, napot_mask, 2'b11} + BW'(1);
        valid = 1'b1;
      end
`ifdef PMP_TOR_MODE_EN
      PMP_A_TOR: begin
        base  = {1'b0, prev_pmpaddr_i, 2'b00};
        top   = {1'b0, pmpaddr_i, 2'b00};
        valid = (base < top);
      end
`endif
      default: ;
    endcase
    hit_o  = valid && (lo_i < top) && (hi_i >= base);
    full_o = valid && (lo_i >= base) && (hi_i < top);
  end

endmodule

// File: rtl/pmp_scan_ctrl.sv
// Sequential PMP checker: scans entries 0..N-1 one per cycle through a single shared matcher.
// Define PMP_TOR_MODE_EN to decode A=TOR; otherwise TOR entries never match.
module pmp_scan_ctrl
  import pmp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ADDR_W      = 32,
  localparam int unsigned IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [2:0]                    req_size,
  input  logic [2:0]                    req_acc,
  input  logic [1:0]                    req_priv,
  input  logic [NUM_ENTRIES*ADDR_W-1:0] pmpaddr_i,
  input  logic [NUM_ENTRIES*CFG_W-1:0]  pmpcfg_i,
  output logic                          busy,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_allow,
  output logic                          resp_hit,
  output logic [IDX_W-1:0]              resp_idx
);

  localparam int unsigned BW = ADDR_W + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  pmp_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BW-1:0]     lo_q, lo_d, hi_q, hi_d;
  logic [2:0]        acc_q, acc_d;
  logic [1:0]        priv_q, priv_d;
  logic              allow_q, allow_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;

  logic [2:0]        size_m1;
  logic [ADDR_W-1:0] cur_addr;
  pmp_cfg_t          cur_cfg;
  logic              m_hit, m_full;
  logic              acc_ok;
  logic              unused_cfg_rsvd;

  // Entry selection for the shared matcher
  always_comb begin
    cur_addr = pmpaddr_i[int'(idx_q)*ADDR_W +: ADDR_W];
    cur_cfg  = pmp_cfg_t'(pmpcfg_i[int'(idx_q)*CFG_W +: CFG_W]);
  end

  assign unused_cfg_rsvd = ^cur_cfg.rsvd;
  assign acc_ok          = is_onehot3(acc_q);

`ifdef PMP_TOR_MODE_EN
  logic [ADDR_W-1:0] prev_addr;

  always_comb begin
    prev_addr = '0;
    if (idx_q != '0) prev_addr = pmpaddr_i[(int'(idx_q) - 1)*ADDR_W +: ADDR_W];
  end
`endif

  pmp_entry_match #(
    .ADDR_W(ADDR_W)
  ) u_match (
    .pmpaddr_i     (cur_addr),
`ifdef PMP_TOR_MODE_EN
    .prev_pmpaddr_i(prev_addr),
`endif
    .a_i           (cur_cfg.a),
    .lo_i          (lo_q),
    .hi_i          (hi_q),
    .hit_o         (m_hit),
    .full_o        (m_full)
  );

  always_comb begin
    size_m1 = (req_size == 3'd0) ? 3'd0 : req_size - 3'd1;
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      acc_q        <= '0;
      priv_q       <= '0;
      allow_q      <= 1'b0;
      hit_q        <= 1'b0;
      ridx_q       <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      acc_q        <= acc_d;
      priv_q       <= priv_d;
      allow_q      <= allow_d;
      hit_q        <= hit_d;
      ridx_q       <= ridx_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state and scan datapath
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    priv_d  = priv_q;
    allow_d = allow_q;
    hit_d   = hit_q;
    ridx_d  = ridx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          lo_d    = BW'(req_addr);
          hi_d    = BW'(req_addr) + BW'(size_m1);
          acc_d   = req_acc;
          priv_d  = req_priv;
          allow_d = 1'b0;
          hit_d   = 1'b0;
          ridx_d  = '0;
        end
      end
      ST_SCAN: begin
        if (acc_ok && m_hit) begin
          // Partial overlap still terminates the scan, but is always denied
          state_d = ST_RESP;
          hit_d   = 1'b1;
          ridx_d  = idx_q;
          allow_d = m_full && (((priv_q == PRIV_M) && !cur_cfg.l) ||
                               (|({cur_cfg.x, cur_cfg.w, cur_cfg.r} & acc_q)));
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_RESP;
          hit_d   = 1'b0;
          ridx_d  = '0;
          allow_d = acc_ok && (priv_q == PRIV_M);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags follow the next state so they are registered with it
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_allow = allow_q;
  assign resp_hit   = hit_q;
  assign resp_idx   = ridx_q;

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// Directed self-checking bench for pmp_scan_ctrl (N=8, ADDR_W=32); expectations follow PMP_TOR_MODE_EN.
module tb_pmp_scan_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_size, req_acc;
  logic [1:0]    req_priv;
  logic [N*AW-1:0] pmpaddr_v;
  logic [N*8-1:0]  pmpcfg_v;
  logic          busy, resp_valid, resp_ready, resp_allow, resp_hit;
  logic [2:0]    resp_idx;

  logic [AW-1:0] pa [N];
  logic [7:0]    pc [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pmpaddr_v[i*AW +: AW] = pa[i];
      pmpcfg_v[i*8 +: 8]    = pc[i];
    end
  end

  pmp_scan_ctrl #(.NUM_ENTRIES(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_acc   (req_acc),
    .req_priv  (req_priv),
    .pmpaddr_i (pmpaddr_v),
    .pmpcfg_i  (pmpcfg_v),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_allow(resp_allow),
    .resp_hit  (resp_hit),
    .resp_idx  (resp_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_pmp();
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pc[i] = '0;
    end
  endtask

  // Issue one request and wait (bounded) for the response; returns edges from accept to resp_valid
  task automatic issue(input logic [31:0] addr, input logic [2:0] size, input logic [2:0] acc,
                       input logic [1:0] priv, output int lat);
    @(negedge clk);
    req_addr  = addr;
    req_size  = size;
    req_acc   = acc;
    req_priv  = priv;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] addr, input logic [2:0] size,
                     input logic [2:0] acc, input logic [1:0] priv,
                     input logic exp_allow, input logic exp_hit, input logic [2:0] exp_idx,
                     input int exp_lat);
    int lat;
    issue(addr, size, acc, priv, lat);
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".allow"}, 32'(resp_allow), 32'(exp_allow));
    check({tag, ".hit"}, 32'(resp_hit), 32'(exp_hit));
    check({tag, ".idx"}, 32'(resp_idx), 32'(exp_idx));
    release_resp();
    check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_acc    = '0;
    req_priv   = '0;
    resp_ready = 1'b0;
    clear_pmp();
    #12;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.allow", 32'(resp_allow), 32'd0);
    check("rst.hit", 32'(resp_hit), 32'd0);
    check("rst.idx", 32'(resp_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // NAPOT 4 KiB at 0x8000_0000, R only
    pa[0] = 32'h2000_01FF;
    pc[0] = 8'h19;
    run("t1_u_read", 32'h8000_0100, 3'd4, 3'b001, 2'b00, 1'b1, 1'b1, 3'd0, 1);
    run("t2_u_write", 32'h8000_0100, 3'd4, 3'b010, 2'b00, 1'b0, 1'b1, 3'd0, 1);
    run("t2_m_write", 32'h8000_0100, 3'd4, 3'b010, 2'b11, 1'b1, 1'b1, 3'd0, 1);
    pc[0] = 8'h99;
    run("t2_m_write_lock", 32'h8000_0100, 3'd4, 3'b010, 2'b11, 1'b0, 1'b1, 3'd0, 1);
    run("t2_m_read_lock", 32'h8000_0100, 3'd4, 3'b001, 2'b11, 1'b1, 1'b1, 3'd0, 1);

    // Entry 5 NAPOT 0x1000..0x1FFF RWX
    clear_pmp();
    pa[5] = 32'h0000_05FF;
    pc[5] = 8'h1F;
    run("t3_partial", 32'h0000_1FFE, 3'd4, 3'b001, 2'b00, 1'b0, 1'b1, 3'd5, 6);
    run("t3_full", 32'h0000_1FFC, 3'd4, 3'b001, 2'b00, 1'b1, 1'b1, 3'd5, 6);
    run("t3_size0", 32'h0000_1FFF, 3'd0, 3'b010, 2'b00, 1'b1, 1'b1, 3'd5, 6);
    run("t4_not_onehot", 32'h0000_1800, 3'd4, 3'b011, 2'b11, 1'b0, 1'b0, 3'd0, 8);

    clear_pmp();
    run("t4_u_fetch_off", 32'h0000_1000, 3'd4, 3'b100, 2'b00, 1'b0, 1'b0, 3'd0, 8);
    run("t4_m_fetch_off", 32'h0000_1000, 3'd4, 3'b100, 2'b11, 1'b1, 1'b0, 3'd0, 8);

    // NA4 at 0x400 and its upper boundary
    pa[2] = 32'h0000_0100;
    pc[2] = 8'h11;
    run("na4_in", 32'h0000_0402, 3'd2, 3'b001, 2'b00, 1'b1, 1'b1, 3'd2, 3);
    run("na4_above", 32'h0000_0404, 3'd1, 3'b001, 2'b00, 1'b0, 1'b0, 3'd0, 8);

    // All-ones NAPOT covers the whole space
    clear_pmp();
    pa[7] = 32'hFFFF_FFFF;
    pc[7] = 8'h1C;
    run("napot_all", 32'hFFFF_FFFC, 3'd4, 3'b100, 2'b00, 1'b1, 1'b1, 3'd7, 8);

    // TOR [0,0x1000) and [0x1000,0x2000), RW
    clear_pmp();
    pa[0] = 32'h0000_0400;
    pc[0] = 8'h0B;
    pa[1] = 32'h0000_0800;
    pc[1] = 8'h0B;
`ifdef PMP_TOR_MODE_EN
    run("t5_tor", 32'h0000_1800, 3'd4, 3'b001, 2'b00, 1'b1, 1'b1, 3'd1, 2);
`else
    run("t5_tor_off", 32'h0000_1800, 3'd4, 3'b001, 2'b00, 1'b0, 1'b0, 3'd0, 8);
`endif

    // Response held while resp_ready stays low
    clear_pmp();
    pa[3] = 32'h0000_0100;
    pc[3] = 8'h11;
    issue(32'h0000_0400, 3'd4, 3'b001, 2'b00, lat);
    check("t6_lat", 32'(lat), 32'd4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("t6_hold.valid", 32'(resp_valid), 32'd1);
      check("t6_hold.req_ready", 32'(req_ready), 32'd0);
      check("t6_hold.busy", 32'(busy), 32'd1);
      check("t6_hold.allow", 32'(resp_allow), 32'd1);
      check("t6_hold.idx", 32'(resp_idx), 32'd3);
    end
    release_resp();
    check("t6_released.valid", 32'(resp_valid), 32'd0);
    check("t6_released.req_ready", 32'(req_ready), 32'd1);

    // Reset pulse mid-scan discards the request
    clear_pmp();
    @(negedge clk);
    req_addr  = 32'h0000_2000;
    req_size  = 3'd4;
    req_acc   = 3'b001;
    req_priv  = 2'b11;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_midscan.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst.valid", 32'(resp_valid), 32'd0);
    check("t6_rst.req_ready", 32'(req_ready), 32'd1);
    check("t6_rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_post_rst.valid", 32'(resp_valid), 32'd0);
    run("t6_after_rst", 32'h0000_2000, 3'd4, 3'b001, 2'b11, 1'b1, 1'b0, 3'd0, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
